// File: rtl/bus_datapath.sv
// Register/ALU datapath of the 9-bit processor: R0-R7, A, G, IR and a latched shared bus.
// Latency: drive, load and ALU results are all visible 1 clock after the edge; outputs are registered.
// Backpressure: none, every action completes in one edge. Optional BUS_DATAPATH_FLAGS_EN adds flag_z/flag_c.
module bus_datapath #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       addr,
    input  logic             val,
    input  logic [2:0]       opcode,
    input  logic             aluen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] bus,
`ifdef BUS_DATAPATH_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
`endif
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] r_q [8];
    logic [WIDTH-1:0] r_d [8];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = bus_q;
        case (opcode)
            3'b010:  alu_res = a_q + bus_q;
            3'b011:  alu_res = a_q - bus_q;
            3'b100:  alu_res = a_q & bus_q;
            3'b101:  alu_res = a_q | bus_q;
            3'b110:  alu_res = a_q ^ bus_q;
            3'b111:  alu_res = {a_q[WIDTH-2:0], 1'b0};
            default: alu_res = bus_q;
        endcase
    end

    // ALU strobe wins over any transfer; loads only ever see the previously latched bus.
    always_comb begin
        r_d   = r_q;
        a_d   = a_q;
        g_d   = g_q;
        ir_d  = ir_q;
        bus_d = bus_q;
        if (aluen) begin
            g_d = alu_res;
        end else if (val) begin
            if (!addr[3]) begin
                bus_d = r_q[addr[2:0]];
            end else begin
                case (addr[2:0])
                    3'd0:    bus_d = din;
                    3'd1:    bus_d = a_q;
                    3'd2:    bus_d = g_q;
                    3'd3:    bus_d = ir_q;
                    default: bus_d = bus_q;
                endcase
            end
        end else begin
            if (!addr[3]) begin
                r_d[addr[2:0]] = bus_q;
            end else if (addr[2:0] == 3'd1) begin
                a_d = bus_q;
            end else if (addr[2:0] == 3'd3) begin
                ir_d = bus_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) r_q[i] <= '0;
            a_q   <= '0;
            g_q   <= '0;
            ir_q  <= '0;
            bus_q <= '0;
        end else begin
            r_q   <= r_d;
            a_q   <= a_d;
            g_q   <= g_d;
            ir_q  <= ir_d;
            bus_q <= bus_d;
        end
    end

    assign ir  = ir_q;
    assign bus = bus_q;
    assign g   = g_q;

`ifdef BUS_DATAPATH_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    // Add carry-out is recovered from the wrapped sum being smaller than A.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (aluen) begin
            flag_z_d = (alu_res == '0);
            case (opcode)
                3'b010:  flag_c_d = (alu_res < a_q);
                3'b011:  flag_c_d = (a_q < bus_q);
                3'b111:  flag_c_d = a_q[WIDTH-1];
                default: flag_c_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: fetch, moves, ALU ops, priority and asynchronous reset.
module tb_bus_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] addr = 4'd12;
    logic       val = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic       aluen = 1'b0;
    logic [8:0] din = 9'h000;
    logic [8:0] ir, bus, g;
`ifdef BUS_DATAPATH_FLAGS_EN
    logic       flag_z, flag_c;
`endif
    int errors = 0;
    int checks = 0;

    bus_datapath #(.WIDTH(9)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .val    (val),
        .opcode (opcode),
        .aluen  (aluen),
        .din    (din),
        .ir     (ir),
        .bus    (bus),
`ifdef BUS_DATAPATH_FLAGS_EN
        .flag_z (flag_z),
        .flag_c (flag_c),
`endif
        .g      (g)
    );

    always #5 clk = ~clk;

    task automatic uop(input logic [3:0] a, input logic v, input logic en, input logic [2:0] op, input int n = 2);
        @(negedge clk);
        addr = a; val = v; aluen = en; opcode = op;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (ir !== 9'h000) begin errors++; $display("FAIL reset_ir: got %h want 000", ir); end
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL reset_bus: got %h want 000", bus); end
        checks++; if (g !== 9'h000) begin errors++; $display("FAIL reset_g: got %h want 000", g); end
        din = 9'h155;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd5, 1'b0, 1'b0, 3'b000);
        uop(4'd9, 1'b0, 1'b0, 3'b000);
        uop(4'd11, 1'b0, 1'b0, 3'b000);
        uop(4'd0, 1'b0, 1'b1, 3'b000);
        checks++; if (ir !== 9'h155) begin errors++; $display("FAIL pre_reset_ir: got %h want 155", ir); end
        checks++; if (g !== 9'h155) begin errors++; $display("FAIL pre_reset_g: got %h want 155", g); end
        @(negedge clk);
        addr = 4'd8; val = 1'b1; aluen = 1'b0; din = 9'h0AA;
        #2 reset = 1'b0; #1;
        checks++; if (ir !== 9'h000) begin errors++; $display("FAIL async_ir: got %h want 000", ir); end
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL async_bus: got %h want 000", bus); end
        checks++; if (g !== 9'h000) begin errors++; $display("FAIL async_g: got %h want 000", g); end
`ifdef BUS_DATAPATH_FLAGS_EN
        checks++; if ({flag_z, flag_c} !== 2'b00) begin errors++; $display("FAIL async_flags: got %b want 00", {flag_z, flag_c}); end
`endif
        @(negedge clk); reset = 1'b1;
        uop(4'd5, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL reset_r5: got %h want 000", bus); end
        uop(4'd9, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL reset_a: got %h want 000", bus); end
    endtask

    task automatic test_fetch;
        din = 9'h049;
        uop(4'd8, 1'b1, 1'b0, 3'b101);
        uop(4'd11, 1'b0, 1'b0, 3'b101);
        checks++; if (ir !== 9'h049) begin errors++; $display("FAIL fetch_ir: got %h want 049", ir); end
        checks++; if (bus !== 9'h049) begin errors++; $display("FAIL fetch_bus: got %h want 049", bus); end
    endtask

    task automatic test_move;
        din = 9'h1F0;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd3, 1'b0, 1'b0, 3'b000);
        din = 9'h000;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL move_din0: got %h want 000", bus); end
        uop(4'd3, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h1F0) begin errors++; $display("FAIL move_r3: got %h want 1f0", bus); end
        uop(4'd9, 1'b0, 1'b0, 3'b000);
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd9, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h1F0) begin errors++; $display("FAIL move_a: got %h want 1f0", bus); end
        uop(4'd8, 1'b0, 1'b0, 3'b000);
        uop(4'd10, 1'b0, 1'b0, 3'b000);
        uop(4'd13, 1'b0, 1'b0, 3'b000);
        checks++; if (bus !== 9'h1F0) begin errors++; $display("FAIL noop_bus: got %h want 1f0", bus); end
        checks++; if (g !== 9'h000) begin errors++; $display("FAIL noop_g: got %h want 000", g); end
        din = 9'h0AB;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h0AB) begin errors++; $display("FAIL noop_din: got %h want 0ab", bus); end
        uop(4'd10, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL noop_gdrive: got %h want 000", bus); end
    endtask

    task automatic test_add;
        din = 9'h020;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd1, 1'b0, 1'b0, 3'b000);
        din = 9'h000;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd1, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h020) begin errors++; $display("FAIL add_r1: got %h want 020", bus); end
        uop(4'd2, 1'b0, 1'b1, 3'b010);
        checks++; if (g !== 9'h010) begin errors++; $display("FAIL add_wrap: got %h want 010", g); end
`ifdef BUS_DATAPATH_FLAGS_EN
        checks++; if ({flag_z, flag_c} !== 2'b01) begin errors++; $display("FAIL add_flags: got %b want 01", {flag_z, flag_c}); end
`endif
        uop(4'd10, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h010) begin errors++; $display("FAIL add_gdrive: got %h want 010", bus); end
        uop(4'd4, 1'b0, 1'b0, 3'b000);
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd4, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h010) begin errors++; $display("FAIL add_r4: got %h want 010", bus); end
    endtask

    task automatic test_alu_ops;
        din = 9'h0AA;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd9, 1'b0, 1'b0, 3'b000);
        uop(4'd2, 1'b0, 1'b1, 3'b011);
        checks++; if (g !== 9'h000) begin errors++; $display("FAIL sub_eq: got %h want 000", g); end
`ifdef BUS_DATAPATH_FLAGS_EN
        checks++; if ({flag_z, flag_c} !== 2'b10) begin errors++; $display("FAIL sub_flags: got %b want 10", {flag_z, flag_c}); end
`endif
        din = 9'h101;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd9, 1'b0, 1'b0, 3'b000);
        uop(4'd2, 1'b0, 1'b1, 3'b111);
        checks++; if (g !== 9'h002) begin errors++; $display("FAIL shl: got %h want 002", g); end
`ifdef BUS_DATAPATH_FLAGS_EN
        checks++; if ({flag_z, flag_c} !== 2'b01) begin errors++; $display("FAIL shl_flags: got %b want 01", {flag_z, flag_c}); end
`endif
        din = 9'h0FF;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd2, 1'b0, 1'b1, 3'b100);
        checks++; if (g !== 9'h001) begin errors++; $display("FAIL and: got %h want 001", g); end
        uop(4'd2, 1'b0, 1'b1, 3'b101);
        checks++; if (g !== 9'h1FF) begin errors++; $display("FAIL or: got %h want 1ff", g); end
        uop(4'd2, 1'b0, 1'b1, 3'b110);
        checks++; if (g !== 9'h1FE) begin errors++; $display("FAIL xor: got %h want 1fe", g); end
        uop(4'd2, 1'b0, 1'b1, 3'b001);
        checks++; if (g !== 9'h0FF) begin errors++; $display("FAIL pass: got %h want 0ff", g); end
        uop(4'd2, 1'b0, 1'b1, 3'b011);
        checks++; if (g !== 9'h002) begin errors++; $display("FAIL sub: got %h want 002", g); end
        uop(4'd2, 1'b0, 1'b1, 3'b010);
        checks++; if (g !== 9'h000) begin errors++; $display("FAIL add_zero: got %h want 000", g); end
`ifdef BUS_DATAPATH_FLAGS_EN
        checks++; if ({flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL add_zero_flags: got %b want 11", {flag_z, flag_c}); end
`endif
    endtask

    task automatic test_priority;
        din = 9'h077;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd2, 1'b0, 1'b0, 3'b000);
        din = 9'h033;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd2, 1'b0, 1'b1, 3'b110);
        checks++; if (g !== 9'h132) begin errors++; $display("FAIL prio_g: got %h want 132", g); end
        din = 9'h1AA;
        uop(4'd8, 1'b1, 1'b1, 3'b000);
        checks++; if (bus !== 9'h033) begin errors++; $display("FAIL prio_bus: got %h want 033", bus); end
        checks++; if (g !== 9'h033) begin errors++; $display("FAIL prio_pass: got %h want 033", g); end
        uop(4'd14, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h033) begin errors++; $display("FAIL none_src: got %h want 033", bus); end
        uop(4'd2, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h077) begin errors++; $display("FAIL prio_r2: got %h want 077", bus); end
        uop(4'd2, 1'b0, 1'b0, 3'b000);
        din = 9'h000;
        uop(4'd8, 1'b1, 1'b0, 3'b000);
        uop(4'd2, 1'b1, 1'b0, 3'b000);
        checks++; if (bus !== 9'h077) begin errors++; $display("FAIL same_addr: got %h want 077", bus); end
    endtask

    task automatic test_back_to_back;
        din = 9'h0C3;
        uop(4'd8, 1'b1, 1'b0, 3'b111, 1);
        uop(4'd6, 1'b0, 1'b0, 3'b111, 1);
        din = 9'h000;
        uop(4'd8, 1'b1, 1'b0, 3'b010, 1);
        checks++; if (bus !== 9'h000) begin errors++; $display("FAIL b2b_din: got %h want 000", bus); end
        uop(4'd6, 1'b1, 1'b0, 3'b011, 1);
        checks++; if (bus !== 9'h0C3) begin errors++; $display("FAIL b2b_r6: got %h want 0c3", bus); end
        checks++; if (g !== 9'h033) begin errors++; $display("FAIL opcode_ignored: got %h want 033", g); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_move();
        test_add();
        test_alu_ops();
        test_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
